// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One iteration per cycle; result is committed 33 cycles after the accepting edge.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state, state_d;
    logic              busy_d, done_d, accept, commit;
    logic [CNT_W-1:0]  cnt;
    logic              is_div, neg_q, neg_r, b_zero;
    logic [XLEN-1:0]   b_mag, acc_hi, acc_lo;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag_in;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res_hi, res_lo;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_d = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand magnitudes; op[0] selects the signed variants
    always_comb begin
        a_neg    = op[0] & A[XLEN-1];
        b_neg    = op[0] & B[XLEN-1];
        a_mag    = a_neg ? (~A + XLEN'(1)) : A;
        b_mag_in = b_neg ? (~B + XLEN'(1)) : B;
    end

    // One shift-add / restoring shift-subtract step.
    // The remainder is always below the divisor, so the 32-bit difference cannot wrap.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? b_mag : XLEN'(0))};
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, b_mag};
        div_diff  = div_shift[XLEN-1:0] - b_mag;
    end

    // Sign correction and divide-by-zero override applied at commit
    always_comb begin
        prod   = {acc_hi, acc_lo};
        res_hi = acc_hi;
        res_lo = acc_lo;
        if (is_div) begin
            res_lo = b_zero ? '1 : (neg_q ? (~acc_lo + XLEN'(1)) : acc_lo);
            res_hi = neg_r ? (~acc_hi + XLEN'(1)) : acc_hi;
        end else begin
            if (neg_q) begin
                prod = ~prod + (2*XLEN)'(1);
            end
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end
    end

    // Datapath and architectural HI/LO
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            b_mag  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                is_div <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                b_zero <= (B == '0);
                b_mag  <= b_mag_in;
                acc_hi <= '0;
                acc_lo <= a_mag;
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (is_div) begin
                    acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                    acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                end else begin
                    acc_hi <= mul_sum[XLEN:1];
                    acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                end
            end

            // A launching start takes priority over MTHI/MTLO in the same cycle
            if (commit) begin
                HI <= res_hi;
                LO <= res_lo;
            end else if (state == IDLE && !start) begin
                if (hi_we) HI <= wdata;
                if (lo_we) LO <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected {HI,LO};
// a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] HI, LO;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    logic [63:0] exp_q[$];

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        forever begin
            logic [63:0] e;
            @(negedge clk);
            if (done === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with HI=%h LO=%h, expected no pulse", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {HI, LO}, e);
                end
            end
        end
    end

    // Launch one operation and watch busy/hold/latency; optionally inject
    // ignored start+MTLO mid-flight, or collide MTHI with the launch.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input bit inject, input bit hi_collide);
        logic [31:0] pre_hi, pre_lo;
        int bad_busy, bad_hold, seen0;
        bad_busy = 0;
        bad_hold = 0;
        pre_hi   = HI;
        pre_lo   = LO;
        seen0    = done_seen;
        start = 1'b1; op = o; A = a; B = b;
        if (hi_collide) begin
            hi_we = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        step();  // E0
        start = 1'b0; hi_we = 1'b0; A = '0; B = '0;
        exp_q.push_back(exp);
        for (int i = 0; i <= 32; i++) begin
            if (busy !== 1'b1) bad_busy++;
            if (HI !== pre_hi || LO !== pre_lo) bad_hold++;
            if (inject && i == 4) begin
                start = 1'b1; op = 2'b00; A = 32'd2; B = 32'd2;
                lo_we = 1'b1; wdata = 32'h55;
            end
            if (inject && i == 5) begin
                start = 1'b0; lo_we = 1'b0; A = '0; B = '0;
            end
            if (i < 32) step();
        end
        step();  // E33
        check({name, "_busy_window"}, 64'(bad_busy), 64'd0);
        check({name, "_hilo_hold"}, 64'(bad_hold), 64'd0);
        check({name, "_latency_busy_done"}, 64'({busy, done}), 64'b01);
        step();
        check({name, "_done_single"}, 64'(done_seen - seen0), 64'd1);
    endtask

    initial begin
        int seen0;
        reset = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        // start held during reset must not launch
        start = 1'b1; A = 32'd5; B = 32'd5;
        repeat (2) step();
        start = 1'b0; A = '0; B = '0;
        reset = 1'b1;
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_busy_done", 64'({busy, done}), 64'd0);
        repeat (3) step();
        check("start_in_reset_ignored", 64'(busy), 64'd0);

        // MTHI / MTLO / both in IDLE
        hi_we = 1'b1; wdata = 32'h1234; step(); hi_we = 1'b0;
        check("mthi", {HI, LO}, {32'h1234, 32'h0});
        lo_we = 1'b1; wdata = 32'hABCD; step(); lo_we = 1'b0;
        check("mtlo", {HI, LO}, {32'h1234, 32'hABCD});
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77; step();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo_both", {HI, LO}, {32'h77, 32'h77});

        run_op("mult_3_m4",     2'b01, 32'd3,         32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 1'b0);
        run_op("multu_max",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
        run_op("div_m7_2",      2'b11, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
        run_op("divu_by_zero",  2'b10, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, 1'b0, 1'b0);
        run_op("div_by_zero",   2'b11, 32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 1'b0, 1'b0);
        run_op("div_overflow",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
        run_op("div_7_m2",      2'b11, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0);
        run_op("mult_min_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        run_op("divu_10_3_inj", 2'b10, 32'd10,        32'd3,         64'h0000_0001_0000_0003, 1'b1, 1'b0);
        run_op("multu_hi_coll", 2'b00, 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000, 1'b0, 1'b1);

        // MTHI then abort a MULT with reset at cycle 10
        hi_we = 1'b1; wdata = 32'h1234; step(); hi_we = 1'b0;
        check("mthi_before_abort", 64'(HI), 64'h1234);
        start = 1'b1; op = 2'b01; A = 32'd7; B = 32'd9;
        step();
        start = 1'b0; A = '0; B = '0;
        repeat (9) step();
        check("abort_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b0; step(); reset = 1'b1;
        check("abort_busy_done", 64'({busy, done}), 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        seen0 = done_seen;
        repeat (40) step();
        check("abort_no_done", 64'(done_seen - seen0), 64'd0);

        run_op("multu_after_abort", 2'b00, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b0, 1'b0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
